dm_mmio: RTL and testbench

Data memory of the pipelined MIPS core with memory-mapped peripherals, in the MEM stage. It consumes the EX/MEM address, control and final store data (after lw→sw forwarding) and produces the load data latched into MEM/WB. That load data is also the source for the lw→sw forwarding path. The block holds a word RAM plus a timer, LED and 7-segment registers, and a free-running systick counter. It raises a level interrupt on timer overflow.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/dm_timer.sv | 54 +++++
 rtl/dm_mmio.sv | 105 ++++++++++
 tb/tb_dm_mmio.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MEM-stage data memory and its peripheral window.
package mmio_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

   // Byte offsets of the peripheral registers from the window base.
   localparam logic [31:0] OFF_TH      = 32'h00;
   localparam logic [31:0] OFF_TL      = 32'h04;
   localparam logic [31:0] OFF_TCON    = 32'h08;
   localparam logic [31:0] OFF_LEDS    = 32'h0C;
   localparam logic [31:0] OFF_DIGI    = 32'h10;
   localparam logic [31:0] OFF_SYSTICK = 32'h14;

   // TCON bit positions.
   localparam int TCON_EN  = 0;
   localparam int TCON_IE  = 1;
   localparam int TCON_IRQ = 2;

endpackage

// File: rtl/dm_timer.sv
// Reloading 32-bit timer: TH reload value, TL count, TCON control/status.
// TL counts up while enabled; on TL == all-ones it reloads from TH and, with
// interrupts enabled, latches the sticky status bit that drives irq.
module dm_timer
   import mmio_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we,
   input  logic        tl_we,
   input  logic        tcon_we,
   input  logic [31:0] wr_data,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irq
);

   logic ovf;

   assign ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
   assign irq = tcon[TCON_IRQ];

   // Reload register, software-written only.
   always_ff @(posedge clk) begin
      if (reset)
         th <= '0;
      else if (th_we)
         th <= wr_data;
   end

   // Count register: a software write beats both increment and reload.
   always_ff @(posedge clk) begin
      if (reset)
         tl <= '0;
      else if (tl_we)
         tl <= wr_data;
      else if (ovf)
         tl <= th;
      else if (tcon[TCON_EN])
         tl <= tl + 32'd1;
   end

   // Control/status: a software write beats the overflow setting the status bit.
   always_ff @(posedge clk) begin
      if (reset)
         tcon <= '0;
      else if (tcon_we)
         tcon <= wr_data[2:0];
      else if (ovf && tcon[TCON_IE])
         tcon[TCON_IRQ] <= 1'b1;
   end

endmodule

// File: rtl/dm_mmio.sv
// MEM-stage data memory: word RAM at the bottom of the address space plus a
// peripheral window (timer, LEDs, 7-segment, systick). Loads are combinational
// so the MEM/WB register and the lw->sw forwarding path see them directly.
module dm_mmio
   import mmio_pkg::*;
#(
   parameter int          RAM_WORDS = 256,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic [7:0]  leds,
   output logic [11:0] digi,
   output logic        irq
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   logic [31:0]   ram [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic [29:0]   mmio_off;
   logic [31:0]   off_byte;
   logic          sel_th, sel_tl, sel_tcon, sel_leds, sel_digi, sel_systick;
   logic [31:0]   th, tl, systick;
   logic [2:0]    tcon;
   logic          unused_addr_lsbs;

   // Byte lanes are not supported; the low address bits play no part.
   assign unused_addr_lsbs = ^addr[1:0];

   assign ram_hit  = ({addr[31:2], 2'b00} < RAM_BYTES);
   assign ram_idx  = addr[AW+1:2];

   // Word distance from the window base; addresses below the base wrap to a
   // large value and match nothing.
   assign mmio_off = addr[31:2] - MMIO_BASE[31:2];
   assign off_byte = {mmio_off, 2'b00};

   assign sel_th      = (off_byte == OFF_TH);
   assign sel_tl      = (off_byte == OFF_TL);
   assign sel_tcon    = (off_byte == OFF_TCON);
   assign sel_leds    = (off_byte == OFF_LEDS);
   assign sel_digi    = (off_byte == OFF_DIGI);
   assign sel_systick = (off_byte == OFF_SYSTICK);

   dm_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .th_we   (mem_wr && sel_th),
      .tl_we   (mem_wr && sel_tl),
      .tcon_we (mem_wr && sel_tcon),
      .wr_data (wr_data),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irq     (irq)
   );

   // RAM keeps its contents across reset; a store colliding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && mem_wr && ram_hit)
         ram[ram_idx] <= wr_data;
   end

   // LED and 7-segment output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         leds <= '0;
         digi <= '0;
      end else if (mem_wr) begin
         if (sel_leds) leds <= wr_data[7:0];
         if (sel_digi) digi <= wr_data[11:0];
      end
   end

   // Free-running cycle counter; read-only from software.
   always_ff @(posedge clk) begin
      if (reset)
         systick <= '0;
      else
         systick <= systick + 32'd1;
   end

   // Load data mux; zero when no load is in flight or the address is unmapped.
   always_comb begin
      rd_data = '0;
      if (mem_rd) begin
         if (ram_hit)          rd_data = ram[ram_idx];
         else if (sel_th)      rd_data = th;
         else if (sel_tl)      rd_data = tl;
         else if (sel_tcon)    rd_data = {29'd0, tcon};
         else if (sel_leds)    rd_data = {24'd0, leds};
         else if (sel_digi)    rd_data = {20'd0, digi};
         else if (sel_systick) rd_data = systick;
      end
   end

endmodule

// File: tb/tb_dm_mmio.sv
// Directed bench for dm_mmio: RAM, read/write collision, peripherals, timer
// reload/interrupt, timer write collisions and reset behaviour.
module tb_dm_mmio;

   localparam logic [31:0] BASE    = 32'h4000_0000;
   localparam logic [31:0] A_TH    = BASE + 32'h00;
   localparam logic [31:0] A_TL    = BASE + 32'h04;
   localparam logic [31:0] A_TCON  = BASE + 32'h08;
   localparam logic [31:0] A_LEDS  = BASE + 32'h0C;
   localparam logic [31:0] A_DIGI  = BASE + 32'h10;
   localparam logic [31:0] A_STICK = BASE + 32'h14;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [7:0]  leds;
   logic [11:0] digi;
   logic        irq;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   dm_mmio #(.RAM_WORDS(256), .MMIO_BASE(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .mem_rd  (mem_rd),
      .mem_wr  (mem_wr),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .leds    (leds),
      .digi    (digi),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
      end
   endtask

   // One clock edge; cyc mirrors the number of edges since reset released.
   task automatic tick();
      @(posedge clk);
      if (reset) cyc = 0;
      else       cyc++;
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_wr  = 1'b1;
      addr    = a;
      wr_data = d;
      tick();
      mem_wr  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mem_rd = 1'b1;
      addr   = a;
      #1;
      chk(tag, rd_data, exp);
      mem_rd = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wr_data = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      chk("rst_leds", {24'd0, leds}, 32'h0);
      chk("rst_digi", {20'd0, digi}, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      addr = A_TL; #1;
      chk("rd_idle_zero", rd_data, 32'h0);
      rd_chk("rst_th", A_TH, 32'h0);
      rd_chk("rst_tl", A_TL, 32'h0);
      rd_chk("rst_tcon", A_TCON, 32'h0);
      rd_chk("rst_systick", A_STICK, 32'h0);

      // RAM access
      wr(32'h10, 32'hDEAD_BEEF);
      rd_chk("ram_rd", 32'h10, 32'hDEAD_BEEF);
      rd_chk("ram_rd_lsbs", 32'h13, 32'hDEAD_BEEF);
      rd_chk("ram_oor", 32'h400, 32'h0);

      // Same-cycle read and write
      wr(32'h20, 32'd5);
      mem_rd = 1'b1; mem_wr = 1'b1; addr = 32'h20; wr_data = 32'd9; #1;
      chk("rdwr_old", rd_data, 32'd5);
      tick();
      mem_wr = 1'b0; #1;
      chk("rdwr_new", rd_data, 32'd9);
      mem_rd = 1'b0;

      // Peripheral registers
      wr(A_LEDS, 32'hFFFF_FFA5);
      chk("leds_out", {24'd0, leds}, 32'hA5);
      wr(A_DIGI, 32'hFFFF_F3F7);
      chk("digi_out", {20'd0, digi}, 32'h3F7);
      rd_chk("leds_rd", A_LEDS, 32'hA5);
      rd_chk("digi_rd", A_DIGI, 32'h3F7);
      wr(A_STICK, 32'h1234_5678);
      rd_chk("systick_wr_ign", A_STICK, 32'(cyc));
      tick(); tick(); tick();
      rd_chk("systick_gap", A_STICK, 32'(cyc));
      rd_chk("unmapped_rd", BASE + 32'h18, 32'h0);
      wr(A_TCON, 32'hFFFF_FFF8);
      rd_chk("tcon_upper", A_TCON, 32'h0);

      // Timer reload and interrupt
      wr(A_TH, 32'hFFFF_FFF0);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_TCON, 32'h3);
      rd_chk("tmr_no_inc_yet", A_TL, 32'hFFFF_FFFE);
      tick();
      rd_chk("tmr_max", A_TL, 32'hFFFF_FFFF);
      chk("tmr_irq_pre", {31'd0, irq}, 32'h0);
      tick();
      rd_chk("tmr_reload", A_TL, 32'hFFFF_FFF0);
      chk("tmr_irq_set", {31'd0, irq}, 32'h1);
      rd_chk("tmr_tcon_st", A_TCON, 32'h7);
      tick();
      rd_chk("tmr_post_inc", A_TL, 32'hFFFF_FFF1);
      chk("tmr_irq_sticky", {31'd0, irq}, 32'h1);
      wr(A_TCON, 32'h3);
      chk("tmr_irq_clr", {31'd0, irq}, 32'h0);

      // TL write on the overflow edge
      wr(A_TL, 32'hFFFF_FFFE);
      tick();
      rd_chk("col_tl_max", A_TL, 32'hFFFF_FFFF);
      wr(A_TL, 32'h100);
      rd_chk("col_tl_win", A_TL, 32'h100);
      chk("col_tl_irq", {31'd0, irq}, 32'h1);
      tick();
      rd_chk("col_tl_inc", A_TL, 32'h101);

      // TCON write on the overflow edge
      wr(A_TCON, 32'h3);
      chk("col_tcon_clr", {31'd0, irq}, 32'h0);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TCON, 32'h1);
      chk("col_tcon_irq", {31'd0, irq}, 32'h0);
      rd_chk("col_tcon_reload", A_TL, 32'hFFFF_FFF0);
      rd_chk("col_tcon_val", A_TCON, 32'h1);

      // Reset while running with irq high; colliding store must be dropped
      wr(A_TCON, 32'h3);
      wr(A_TL, 32'hFFFF_FFFF);
      tick();
      chk("pre_rst_irq", {31'd0, irq}, 32'h1);
      reset = 1'b1; mem_wr = 1'b1; addr = 32'h10; wr_data = 32'h0;
      tick();
      reset = 1'b0; mem_wr = 1'b0;
      chk("rst2_irq", {31'd0, irq}, 32'h0);
      chk("rst2_leds", {24'd0, leds}, 32'h0);
      chk("rst2_digi", {20'd0, digi}, 32'h0);
      rd_chk("rst2_th", A_TH, 32'h0);
      rd_chk("rst2_tl", A_TL, 32'h0);
      rd_chk("rst2_tcon", A_TCON, 32'h0);
      rd_chk("rst2_systick", A_STICK, 32'h0);
      rd_chk("rst2_ram", 32'h10, 32'hDEAD_BEEF);
      tick();
      rd_chk("rst2_tl_idle", A_TL, 32'h0);
      rd_chk("rst2_systick_run", A_STICK, 32'(cyc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
